// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding, stream-format constants and defaults for the
// serial instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int          BYTES_PER_WORD  = 4;
    localparam int          MAX_WORDS       = 256;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

    // A count byte of zero stands for the full 256-word image.
    function automatic logic [8:0] words_from_count(input logic [7:0] c);
        return (c == 8'd0) ? 9'(MAX_WORDS) : {1'b0, c};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs accepted bytes little-endian into 32-bit words, flags each
// completed word one cycle later and keeps the running XOR checksum.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [7:0]  csum_o
);

    logic [31:0] word_q;
    logic        valid_q;
    logic [7:0]  csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            csum_q  <= '0;
        end else begin
            valid_q <= byte_en_i && (lane_i == 2'(BYTES_PER_WORD - 1));
            if (clear_i)
                csum_q <= '0;
            else if (byte_en_i)
                csum_q <= csum_q ^ byte_i;
            if (byte_en_i)
                word_q[8*lane_i +: 8] <= byte_i;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a count/data/checksum byte stream and writes it as 32-bit
// words into instruction memory while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [15:0] TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [7:0]  BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_en,
    output logic [7:0]  write_addr,
    output logic [31:0] write_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t      state_q, state_d;
    logic [7:0]  count_q;
    logic [9:0]  byte_cnt_q;
    logic [8:0]  word_cnt_q;
    logic [15:0] idle_q;
    logic [7:0]  waddr_q;
    logic [7:0]  csum;
    logic [8:0]  n_words;
    logic        busy, start, accept, data_en, lane_last, last_byte, timeout;

    assign busy      = state_q inside {S_COUNT, S_DATA, S_CHECK};
    assign start     = load_start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign accept    = busy && byte_valid;
    assign data_en   = accept && (state_q == S_DATA);
    assign n_words   = words_from_count(count_q);
    assign lane_last = byte_cnt_q[1:0] == 2'(BYTES_PER_WORD - 1);
    assign last_byte = lane_last && (word_cnt_q == n_words - 9'd1);
    assign timeout   = busy && !accept && (idle_q + 16'd1 == TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = start ? S_COUNT : state_q;
            S_COUNT: state_d = accept ? S_DATA : (timeout ? S_ERR : state_q);
            S_DATA:  state_d = (accept && last_byte) ? S_CHECK : (timeout ? S_ERR : state_q);
            S_CHECK: state_d = accept ? ((byte_data == csum) ? S_DONE : S_ERR) : (timeout ? S_ERR : state_q);
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = busy;
        cpu_hold   = busy;
        done       = state_q == S_DONE;
        error      = state_q == S_ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            idle_q     <= '0;
            waddr_q    <= '0;
        end else if (start) begin
            count_q    <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            idle_q     <= '0;
        end else if (busy) begin
            idle_q <= accept ? '0 : idle_q + 16'd1;
            if (accept && state_q == S_COUNT)
                count_q <= byte_data;
            if (data_en) begin
                byte_cnt_q <= byte_cnt_q + 10'd1;
                if (lane_last) begin
                    word_cnt_q <= word_cnt_q + 9'd1;
                    waddr_q    <= BASE_ADDR + word_cnt_q[7:0];
                end
            end
        end
    end

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .byte_en_i    (data_en),
        .lane_i       (byte_cnt_q[1:0]),
        .byte_i       (byte_data),
        .word_o       (write_data),
        .word_valid_o (write_en),
        .csum_o       (csum)
    );

    assign write_addr = waddr_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream stimulus with a queue scoreboard of expected
// memory writes and end-of-load status checks.
module tb_imem_loader;

    localparam logic [15:0] TO   = 16'd16;
    localparam logic [7:0]  BASE = 8'h80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, write_en, cpu_hold, done, error;
    logic [7:0]  write_addr;
    logic [31:0] write_data;

    int compared = 0;
    int mismatched = 0;
    logic [39:0] exp_q[$];
    logic [31:0] wr[256];

    imem_loader #(.TIMEOUT(TO), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && write_en) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", write_addr, write_data);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {24'h0, write_addr}, {24'h0, e[39:32]});
                chk("write_data", write_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit noise);
        int n;
        repeat ($urandom_range(0, 4)) begin
            byte_valid = 1'b0;
            load_start = noise && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        load_start = noise && ($urandom_range(0, 2) == 0);
        n = 0;
        while (!byte_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 64) begin
            compared++;
            mismatched++;
            $display("FAIL byte_ready_wait: got ready 0 for 64 cycles expected 1");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic pulse_start(input bit coincide, input logic [7:0] cnt);
        load_start = 1'b1;
        if (coincide) begin
            byte_valid = 1'b1;
            byte_data  = cnt;
            #1 chk("ready_on_start", {31'h0, byte_ready}, 32'h0);
        end
        @(posedge clk); #1;
        load_start = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Reference: word i goes to (BASE+i) mod 256; checksum is the XOR of every data byte.
    task automatic run_load(input int n, input bit bad, input bit noise, input bit coincide);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'((int'(BASE) + i) % 256), wr[i]});
            for (int k = 0; k < 4; k++) cs ^= wr[i][8*k +: 8];
        end
        pulse_start(coincide, 8'(n % 256));
        send_byte(8'(n % 256), 1'b0);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) send_byte(wr[i][8*k +: 8], noise);
        send_byte(bad ? ~cs : cs, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("done", {31'h0, done}, {31'h0, !bad});
        chk("error", {31'h0, error}, {31'h0, bad});
        chk("cpu_hold_after", {31'h0, cpu_hold}, 32'h0);
        chk("writes_pending", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, {31'h0, byte_ready}, 32'h0);
        chk({tag, "_wen"}, {31'h0, write_en}, 32'h0);
        chk({tag, "_hold"}, {31'h0, cpu_hold}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_error"}, {31'h0, error}, 32'h0);
        chk({tag, "_addr"}, {24'h0, write_addr}, 32'h0);
        chk({tag, "_data"}, write_data, 32'h0);
    endtask

    initial begin
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        wr[0] = 32'h00000013;
        wr[1] = 32'h00100093;
        run_load(2, 1'b0, 1'b0, 1'b0);
        run_load(2, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 256; i++) wr[i] = $urandom;
        run_load(256, 1'b0, 1'b1, 1'b0);

        // Stall after two data bytes until the idle limit forces an error.
        pulse_start(1'b0, 8'd3);
        send_byte(8'd3, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        repeat (10) @(posedge clk);
        #1 chk("hold_before_timeout", {31'h0, cpu_hold}, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        chk("timeout_error", {31'h0, error}, 32'h1);
        chk("timeout_done", {31'h0, done}, 32'h0);
        chk("timeout_hold", {31'h0, cpu_hold}, 32'h0);

        // Reset in the middle of the second word.
        for (int i = 0; i < 3; i++) wr[i] = $urandom;
        exp_q.push_back({BASE, wr[0]});
        pulse_start(1'b0, 8'd3);
        send_byte(8'd3, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(wr[0][8*k +: 8], 1'b0);
        send_byte(wr[1][7:0], 1'b0);
        send_byte(wr[1][15:8], 1'b0);
        #2 rst = 1'b0;
        #1 chk_zero("midreset");
        chk("midreset_pending", exp_q.size(), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_ready", {31'h0, byte_ready}, 32'h0);
        chk("idle_hold", {31'h0, cpu_hold}, 32'h0);
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) wr[i] = $urandom;
        run_load(3, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) wr[i] = $urandom;
            run_load(n, $urandom_range(0, 3) == 0, 1'b1, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'hFFFF, giving the maximum idle cycles between accepted bytes once a load has started.
REQ-002 The block SHALL have parameter BASE_ADDR, default 8'h00, giving the first word address written.
REQ-003 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port load_start, input, 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 Port byte_valid, input, 1: byte_data is valid.
REQ-007 Port byte_data, input, 8: serial program byte.
REQ-008 Port byte_ready, output, 1: loader accepts the byte this cycle; a byte transfers when byte_valid and byte_ready are both 1.
REQ-009 Port write_en, output, 1: instruction-memory write strobe.
REQ-010 Port write_addr, output, 8: word address of the write.
REQ-011 Port write_data, output, 32: instruction word to write.
REQ-012 Port cpu_hold, output, 1: drives the fetch-stage flush and deasserts read_en while loading.
REQ-013 Port done, output, 1: last load completed with a good checksum.
REQ-014 Port error, output, 1: last load failed on checksum or timeout.

Function
REQ-015 Stream format SHALL be:
- one count byte C, where the word count N = C, and C = 0 means N = 256;
- then 4N data bytes, little-endian per word (first byte = bits 7:0);
- then one checksum byte equal to the XOR of all 4N data bytes.
REQ-016 The state machine SHALL have states IDLE, COUNT, DATA, CHECK, DONE and ERR.
REQ-017 Transitions SHALL be:
- load_start: IDLE/DONE/ERR -> COUNT;
- byte accepted in COUNT -> DATA;
- last data byte accepted in DATA -> CHECK;
- checksum byte accepted in CHECK -> DONE if it matches, else ERR.
REQ-018 byte_ready SHALL be 1 only in COUNT, DATA and CHECK.
REQ-019 In DATA, each 4th accepted byte SHALL complete a word.
REQ-020 On the cycle after a word completes, write_en SHALL be 1 for exactly one cycle, with write_addr = BASE_ADDR + word index and write_data = the assembled word (latency 1 cycle).
REQ-021 write_addr SHALL wrap modulo 256 (8-bit add, carry discarded).
REQ-022 write_en SHALL never assert outside DATA or the single cycle following the last data byte.
REQ-023 cpu_hold SHALL be 1 in COUNT, DATA and CHECK, and 0 otherwise.
REQ-024 done and error SHALL be level outputs set on entry to DONE or ERR respectively, and both cleared on entry to COUNT.
REQ-025 Timeout: an idle counter SHALL reset on each accepted byte, increment in COUNT, DATA and CHECK otherwise, and force ERR on reaching TIMEOUT; no partial word is written.
REQ-026 load_start SHALL be ignored in COUNT, DATA and CHECK.
REQ-027 If load_start and byte_valid coincide in IDLE, the byte SHALL NOT be accepted (byte_ready = 0 that cycle).
REQ-028 The byte counter and word counter SHALL be wide enough for N = 256, i.e. a 10-bit byte count within a word set and a 9-bit word count.

Reset
REQ-029 While rst = 0, the block SHALL go immediately to IDLE, with byte_ready, write_en, cpu_hold, done and error at 0, and write_addr, write_data and all counters and the checksum accumulator at 0.
REQ-030 Reset asserted mid-load SHALL abort with no further write_en pulse, and the block SHALL resume only on a new load_start.

Structure
REQ-031 The state encoding, stream-format constants (bytes per word = 4, C = 0 meaning 256) and the TIMEOUT default SHALL live in a shared package, imem_loader_pkg.
REQ-032 Byte-to-word assembly with XOR accumulation SHALL be one sub-module, word_assembler, and the state machine, counters and timeout SHALL stay in imem_loader.

Verification
REQ-033 Scenario 1: load_start, then C = 8'h02 and bytes 13 00 00 00 93 00 10 00, then checksum 8'h90 -> write_en pulses at addr 0 data 32'h00000013 and addr 1 data 32'h00100093; then done = 1, error = 0, cpu_hold = 0.
REQ-034 Scenario 2: same stream with checksum 8'h91 -> both writes occur, then error = 1, done = 0.
REQ-035 Scenario 3: C = 8'h00, 1024 data bytes, BASE_ADDR = 8'h80 -> exactly 256 writes with addresses 80..FF then 00..7F, then done = 1.
REQ-036 Scenario 4: TIMEOUT = 16, stall byte_valid for 16 cycles after 2 data bytes -> ERR with error = 1, no write_en, cpu_hold = 0.
REQ-037 Scenario 5: rst pulsed low after the first word is written -> outputs go to 0 at once and no second write occurs; a new load then completes normally.
REQ-038 Scenario 6: byte_valid toggling randomly with load_start pulses during DATA -> the written data match the stream and the extra load_start pulses are ignored.
